// File: rtl/sd_slot_pkg.sv
// Shared types and helpers for the SD slot manager and its activity timer.
package sd_slot_pkg;

  // Widest slot index needed for the largest supported slot count (8).
  localparam int MAX_SLOT_W = 3;

  // Slot index as stored internally; upper bits stay zero for small SLOTS.
  typedef logic [MAX_SLOT_W-1:0] slot_idx_t;

  // Mount/selection FSM: IDLE = routing settled, PENDING = switch waits for sdss=1.
  typedef enum logic {
    SEL_IDLE    = 1'b0,
    SEL_PENDING = 1'b1
  } sel_state_t;

  // A routing choice: virtual slot (vsd=1, slot) or physical card (vsd=0).
  typedef struct packed {
    logic      vsd;
    slot_idx_t slot;
  } route_t;

  // Width of the external slot index port; never narrower than one bit.
  function automatic int slot_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sd_slot_mgr_act_timer.sv
// SPI activity detector: registers MOSI/MISO once, restarts a saturating
// counter on any change and reports activity while the counter is below TIMEOUT.
module sd_act_timer #(
  parameter int TIMEOUT = 1000000,
  parameter int CNT_W   = 24
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic mosi,
  input  logic miso,
  output logic active
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic             mosi_reg;
  logic             miso_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             active_reg;

  // Restart on a data edge, otherwise count up and hold at the limit.
  always_comb begin
    cnt_next = cnt_reg;
    if ((mosi != mosi_reg) || (miso != miso_reg)) begin
      cnt_next = '0;
    end else if (cnt_reg < LIMIT) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  // Sample data lines, advance the counter and register the activity flag.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mosi_reg   <= 1'b0;
      miso_reg   <= 1'b0;
      cnt_reg    <= LIMIT;
      active_reg <= 1'b0;
    end else begin
      mosi_reg   <= mosi;
      miso_reg   <= miso;
      cnt_reg    <= cnt_next;
      active_reg <= (cnt_next < LIMIT);
    end
  end

  assign active = active_reg;

endmodule

// File: rtl/sd_slot_mgr.sv
// SD routing/activity manager: tracks mounted virtual images, routes the core
// SPI master to one virtual slot or the physical card, defers switches until
// chip-select is idle, and generates the post-mount reset and activity LED.
module sd_slot_mgr
  import sd_slot_pkg::*;
#(
  parameter int SLOTS            = 2,
  parameter int ACT_TIMEOUT      = 1000000,
  parameter int MOUNT_RST_CYCLES = 10000000,
  parameter int CNT_W            = 24,
  localparam int SLOT_W          = slot_w(SLOTS)
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [SLOTS-1:0]  img_mounted,
  input  logic [SLOTS-1:0]  img_nz,
  input  logic              sdclk,
  input  logic              sdmosi,
  input  logic              sdss,
  output logic              sdmiso,
  output logic [SLOTS-1:0]  vsd_ss,
  input  logic [SLOTS-1:0]  vsd_miso,
  input  logic              SD_MISO,
  output logic              SD_CS,
  output logic              SD_SCK,
  output logic              SD_MOSI,
  output logic              vsd_sel,
  output logic [SLOT_W-1:0] sel_slot,
  output logic              reset_img,
  output logic              sd_act
);

  logic [SLOTS-1:0] mounted_reg;
  logic [SLOTS-1:0] mounted_next;
  sel_state_t       state_reg;
  sel_state_t       state_next;
  route_t           cur_reg;
  route_t           cur_next;
  route_t           pend_reg;
  route_t           pend_next;
  route_t           tgt;
  logic             tgt_valid;
  logic             routed_drop;
  logic [CNT_W-1:0] rst_cnt_reg;
  logic [CNT_W-1:0] rst_cnt_next;
  logic             reset_img_reg;
  logic             miso_virt;

  // Per-slot mount tracking and card-select decode.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    assign mounted_next[gi] = img_mounted[gi] ? img_nz[gi] : mounted_reg[gi];
    assign vsd_ss[gi] = ~(cur_reg.vsd & (cur_reg.slot == slot_idx_t'(gi))) | sdss;
  end

  // Work out the routing target implied by this cycle's mount strobes.
  // A non-empty image always wins (highest index last); losing the routed
  // image falls back to the highest other mounted slot or the physical card.
  always_comb begin
    tgt         = '0;
    tgt_valid   = 1'b0;
    routed_drop = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (img_mounted[i] && !img_nz[i] && cur_reg.vsd &&
          (cur_reg.slot == slot_idx_t'(i))) begin
        routed_drop = 1'b1;
      end
    end
    if (routed_drop) begin
      tgt_valid = 1'b1;
      for (int i = 0; i < SLOTS; i++) begin
        if (mounted_next[i] && (cur_reg.slot != slot_idx_t'(i))) begin
          tgt.vsd  = 1'b1;
          tgt.slot = slot_idx_t'(i);
        end
      end
    end
    for (int i = 0; i < SLOTS; i++) begin
      if (img_mounted[i] && img_nz[i]) begin
        tgt_valid = 1'b1;
        tgt.vsd   = 1'b1;
        tgt.slot  = slot_idx_t'(i);
      end
    end
  end

  // Selection FSM: apply a target only while chip-select is idle, otherwise
  // hold it as pending; a newer target replaces the pending one.
  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    pend_next  = pend_reg;
    case (state_reg)
      SEL_IDLE: begin
        if (tgt_valid) begin
          if (sdss) begin
            cur_next = tgt;
          end else begin
            pend_next  = tgt;
            state_next = SEL_PENDING;
          end
        end
      end
      SEL_PENDING: begin
        if (tgt_valid) begin
          pend_next = tgt;
        end
        if (sdss) begin
          cur_next   = tgt_valid ? tgt : pend_reg;
          pend_next  = '0;
          state_next = SEL_IDLE;
        end
      end
      default: begin
        state_next = SEL_IDLE;
      end
    endcase
  end

  // Mount-reset timer: any strobe reloads it, then it counts down to zero.
  always_comb begin
    rst_cnt_next = rst_cnt_reg;
    if (|img_mounted) begin
      rst_cnt_next = CNT_W'(MOUNT_RST_CYCLES);
    end else if (rst_cnt_reg != '0) begin
      rst_cnt_next = rst_cnt_reg - CNT_W'(1);
    end
  end

  // State registers for mount tracking, routing and the mount-reset pulse.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mounted_reg   <= '0;
      state_reg     <= SEL_IDLE;
      cur_reg       <= '0;
      pend_reg      <= '0;
      rst_cnt_reg   <= '0;
      reset_img_reg <= 1'b0;
    end else begin
      mounted_reg   <= mounted_next;
      state_reg     <= state_next;
      cur_reg       <= cur_next;
      pend_reg      <= pend_next;
      rst_cnt_reg   <= rst_cnt_next;
      reset_img_reg <= (rst_cnt_next != '0);
    end
  end

  // MISO mux from the currently routed virtual slot.
  always_comb begin
    miso_virt = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (cur_reg.slot == slot_idx_t'(i)) begin
        miso_virt = vsd_miso[i];
      end
    end
  end

  assign vsd_sel   = cur_reg.vsd;
  assign sel_slot  = cur_reg.slot[SLOT_W-1:0];
  assign reset_img = reset_img_reg;
  assign SD_CS     = cur_reg.vsd | sdss;
  assign SD_SCK    = sdclk & ~SD_CS;
  assign SD_MOSI   = sdmosi & ~SD_CS;
  assign sdmiso    = cur_reg.vsd ? miso_virt : SD_MISO;

  sd_act_timer #(
    .TIMEOUT (ACT_TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_act_timer (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .mosi    (sdmosi),
    .miso    (sdmiso),
    .active  (sd_act)
  );

endmodule

// File: tb/tb_sd_slot_mgr.sv
// Testbench for sd_slot_mgr: routing vector table, directed mount/reset
// sequences and a randomized run against a behavioural reference model.
module tb_sd_slot_mgr;

  localparam int SLOTS = 2;
  localparam int ACT   = 20;
  localparam int MRST  = 100;
  localparam int CNT_W = 24;

  logic             clk_sys = 1'b0;
  logic             reset_n = 1'b0;
  logic [SLOTS-1:0] img_mounted = '0;
  logic [SLOTS-1:0] img_nz = '0;
  logic             sdclk = 1'b0;
  logic             sdmosi = 1'b0;
  logic             sdss = 1'b1;
  logic             sdmiso;
  logic [SLOTS-1:0] vsd_ss;
  logic [SLOTS-1:0] vsd_miso = '0;
  logic             SD_MISO = 1'b0;
  logic             SD_CS;
  logic             SD_SCK;
  logic             SD_MOSI;
  logic             vsd_sel;
  logic [0:0]       sel_slot;
  logic             reset_img;
  logic             sd_act;

  int tests = 0;
  int fails = 0;

  sd_slot_mgr #(
    .SLOTS            (SLOTS),
    .ACT_TIMEOUT      (ACT),
    .MOUNT_RST_CYCLES (MRST),
    .CNT_W            (CNT_W)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .img_mounted (img_mounted),
    .img_nz      (img_nz),
    .sdclk       (sdclk),
    .sdmosi      (sdmosi),
    .sdss        (sdss),
    .sdmiso      (sdmiso),
    .vsd_ss      (vsd_ss),
    .vsd_miso    (vsd_miso),
    .SD_MISO     (SD_MISO),
    .SD_CS       (SD_CS),
    .SD_SCK      (SD_SCK),
    .SD_MOSI     (SD_MOSI),
    .vsd_sel     (vsd_sel),
    .sel_slot    (sel_slot),
    .reset_img   (reset_img),
    .sd_act      (sd_act)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit       route;   // 0: physical card routed, 1: slot 1 routed
    bit       ss;
    bit       clk_i;
    bit       mosi;
    bit [1:0] vmiso;
    bit       pmiso;
    bit       e_cs;
    bit       e_sck;
    bit       e_mosi;
    bit [1:0] e_ss;
    bit       e_miso;
  } vec_t;

  vec_t vecs[12];

  // Behavioural model state.
  bit m_mounted[SLOTS];
  bit m_vsd;
  int m_slot;
  bit p_valid;
  bit p_vsd;
  int p_slot;
  int rst_left;
  int age;
  bit prev_mosi;
  bit prev_miso;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic strobe(input logic [1:0] mask, input logic [1:0] nz);
    img_mounted = mask;
    img_nz      = nz;
    step();
    img_mounted = '0;
    $display("[TB] strobe mask=%b nz=%b sdss=%b -> vsd_sel=%b sel_slot=%0d", mask, nz, sdss, vsd_sel, sel_slot);
  endtask

  // Number of consecutive cycles the chosen flag stays high, bounded.
  task automatic run_len(input bit use_act, output int n);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      if ((use_act ? sd_act : reset_img) !== 1'b1) break;
      n++;
      step();
    end
  endtask

  task automatic apply_vec(input int idx);
    vec_t v;
    v        = vecs[idx];
    sdss     = v.ss;
    sdclk    = v.clk_i;
    sdmosi   = v.mosi;
    vsd_miso = v.vmiso;
    SD_MISO  = v.pmiso;
    #1;
    chk("vec_cs",   32'(SD_CS),   32'(v.e_cs));
    chk("vec_sck",  32'(SD_SCK),  32'(v.e_sck));
    chk("vec_mosi", 32'(SD_MOSI), 32'(v.e_mosi));
    chk("vec_ss",   32'(vsd_ss),  32'(v.e_ss));
    chk("vec_miso", 32'(sdmiso),  32'(v.e_miso));
    $display("[TB] vec %0d route=%b ss=%b clk=%b mosi=%b vmiso=%b pmiso=%b -> cs=%b sck=%b mosi=%b vss=%b miso=%b",
             idx, v.route, v.ss, v.clk_i, v.mosi, v.vmiso, v.pmiso, SD_CS, SD_SCK, SD_MOSI, vsd_ss, sdmiso);
  endtask

  task automatic model_init();
    for (int i = 0; i < SLOTS; i++) m_mounted[i] = 1'b0;
    m_vsd = 0; m_slot = 0; p_valid = 0; p_vsd = 0; p_slot = 0;
    rst_left = 0; age = ACT; prev_mosi = 0; prev_miso = 0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input logic [1:0] strb, input logic [1:0] nz,
                            input bit ss, input bit mosi, input bit miso);
    bit have;
    bit t_vsd;
    int t_slot;
    have = 0; t_vsd = 0; t_slot = 0;
    for (int i = 0; i < SLOTS; i++) if (strb[i]) m_mounted[i] = nz[i];
    if (m_vsd && strb[m_slot] && !nz[m_slot]) begin
      have = 1;
      for (int j = 0; j < SLOTS; j++) begin
        if (j != m_slot && m_mounted[j]) begin t_vsd = 1; t_slot = j; end
      end
    end
    for (int i = 0; i < SLOTS; i++) begin
      if (strb[i] && nz[i]) begin have = 1; t_vsd = 1; t_slot = i; end
    end
    if (have) begin
      if (ss) begin m_vsd = t_vsd; m_slot = t_slot; p_valid = 0; end
      else begin p_valid = 1; p_vsd = t_vsd; p_slot = t_slot; end
    end else if (p_valid && ss) begin
      m_vsd = p_vsd; m_slot = p_slot; p_valid = 0;
    end
    if (strb != 0) rst_left = MRST;
    else if (rst_left > 0) rst_left--;
    if (mosi != prev_mosi || miso != prev_miso) age = 0;
    else if (age < ACT) age++;
    prev_mosi = mosi;
    prev_miso = miso;
  endtask

  initial begin
    int n;
    int lows;
    bit e_cs;
    bit e_miso;
    bit [1:0] e_ss;
    bit miso_seen;
    logic [1:0] strb_now;
    logic [1:0] nz_now;
    int rate;

    //                 rt ss ck mo vmiso pm | cs sck mo ess  miso
    vecs[0]  = '{0, 0, 1, 1, 2'b00, 1, 0, 1, 1, 2'b11, 1};
    vecs[1]  = '{0, 0, 1, 0, 2'b11, 0, 0, 1, 0, 2'b11, 0};
    vecs[2]  = '{0, 0, 0, 1, 2'b10, 1, 0, 0, 1, 2'b11, 1};
    vecs[3]  = '{0, 1, 1, 1, 2'b11, 1, 1, 0, 0, 2'b11, 1};
    vecs[4]  = '{0, 1, 0, 1, 2'b00, 0, 1, 0, 0, 2'b11, 0};
    vecs[5]  = '{0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 2'b11, 0};
    vecs[6]  = '{1, 0, 1, 1, 2'b10, 0, 1, 0, 0, 2'b01, 1};
    vecs[7]  = '{1, 0, 1, 1, 2'b01, 1, 1, 0, 0, 2'b01, 0};
    vecs[8]  = '{1, 1, 1, 1, 2'b10, 0, 1, 0, 0, 2'b11, 1};
    vecs[9]  = '{1, 1, 0, 0, 2'b00, 1, 1, 0, 0, 2'b11, 0};
    vecs[10] = '{1, 0, 0, 1, 2'b11, 0, 1, 0, 0, 2'b01, 1};
    vecs[11] = '{1, 0, 1, 0, 2'b00, 1, 1, 0, 0, 2'b01, 0};

    // Reset, no stimulus.
    step(); step(); step();
    reset_n = 1'b1;
    step(); step();
    chk("rst_vsd_sel",   32'(vsd_sel),   32'd0);
    chk("rst_reset_img", 32'(reset_img), 32'd0);
    chk("rst_sd_act",    32'(sd_act),    32'd0);
    chk("rst_cs_hi",     32'(SD_CS),     32'd1);
    sdss = 1'b0; #1;
    chk("rst_cs_lo",     32'(SD_CS),     32'd0);
    $display("[TB] reset idle: vsd_sel=%b reset_img=%b sd_act=%b", vsd_sel, reset_img, sd_act);

    // Physical-card routing vectors.
    for (int i = 0; i < 12; i++) if (!vecs[i].route) apply_vec(i);

    // Mount slot 1 with chip-select idle: one-cycle switch and reset pulse length.
    sdss = 1'b1; sdmosi = 1'b0; sdclk = 1'b0; vsd_miso = '0; SD_MISO = 1'b0;
    step();
    strobe(2'b10, 2'b10);
    chk("m1_vsd_sel", 32'(vsd_sel),  32'd1);
    chk("m1_slot",    32'(sel_slot), 32'd1);
    run_len(1'b0, n);
    chk("m1_rst_len", 32'(n), 32'(MRST));
    $display("[TB] reset_img pulse %0d cycles", n);

    // Slot 1 routing vectors.
    for (int i = 0; i < 12; i++) if (vecs[i].route) apply_vec(i);

    // Mount slot 0 during an active transfer: switch waits for sdss=1.
    sdss = 1'b0;
    step();
    strobe(2'b01, 2'b01);
    chk("dfr_slot_0", 32'(sel_slot), 32'd1);
    step(); step(); step();
    chk("dfr_slot_3", 32'(sel_slot), 32'd1);
    chk("dfr_vss",    32'(vsd_ss),   32'b01);
    sdss = 1'b1; #1;
    chk("dfr_slot_ss", 32'(sel_slot), 32'd1);
    step();
    chk("dfr_switch", 32'(sel_slot), 32'd0);
    chk("dfr_vss_idle", 32'(vsd_ss), 32'b11);
    sdss = 1'b0; #1;
    chk("dfr_vss_sel0", 32'(vsd_ss), 32'b10);
    $display("[TB] deferred switch landed: sel_slot=%0d vsd_ss=%b", sel_slot, vsd_ss);
    sdss = 1'b1;

    // Fallback on unmount of the routed image.
    strobe(2'b10, 2'b10);
    chk("fb_sel1", 32'(sel_slot), 32'd1);
    strobe(2'b10, 2'b00);
    chk("fb_vsd",  32'(vsd_sel),  32'd1);
    chk("fb_slot0", 32'(sel_slot), 32'd0);
    strobe(2'b01, 2'b00);
    chk("fb_phys", 32'(vsd_sel),  32'd0);

    // Simultaneous strobes and mid-pulse retrigger.
    strobe(2'b11, 2'b11);
    chk("sim_vsd",  32'(vsd_sel),  32'd1);
    chk("sim_slot", 32'(sel_slot), 32'd1);
    lows = 0;
    for (int k = 0; k < 50; k++) begin
      if (reset_img !== 1'b1) lows++;
      step();
    end
    chk("retrig_first50", 32'(lows), 32'd0);
    strobe(2'b11, 2'b11);
    run_len(1'b0, n);
    chk("retrig_len", 32'(n), 32'(MRST));
    $display("[TB] retrigger: reset_img extended %0d cycles", n);

    // Activity: one MOSI toggle.
    sdmosi = 1'b0; vsd_miso = '0; SD_MISO = 1'b0;
    for (int k = 0; k < 30; k++) step();
    chk("act_idle", 32'(sd_act), 32'd0);
    sdmosi = 1'b1;
    step();
    run_len(1'b1, n);
    chk("act_len", 32'(n), 32'(ACT));
    $display("[TB] sd_act high %0d cycles", n);

    // Reset asserted while a switch is pending.
    sdss = 1'b0;
    strobe(2'b01, 2'b01);
    chk("pr_pending", 32'(sel_slot), 32'd1);
    reset_n = 1'b0; #1;
    chk("pr_vsd",  32'(vsd_sel),   32'd0);
    chk("pr_slot", 32'(sel_slot),  32'd0);
    chk("pr_rimg", 32'(reset_img), 32'd0);
    sdmosi = 1'b0; sdss = 1'b1;
    step(); step();
    reset_n = 1'b1;
    step(); step();
    chk("pr_discard", 32'(vsd_sel), 32'd0);
    $display("[TB] reset mid-pending: vsd_sel=%b", vsd_sel);

    // Randomized run against the reference model.
    model_init();
    for (int c = 0; c < 3000; c++) begin
      rate = (c < 1500) ? 7 : 150;
      if ($urandom_range(0, rate) == 0) strb_now = 2'($urandom_range(1, 3));
      else strb_now = 2'b00;
      nz_now = 2'($urandom_range(0, 3));
      img_mounted = strb_now;
      img_nz      = nz_now;
      if ($urandom_range(0, 3) == 0) sdss = ~sdss;
      sdclk = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) sdmosi = ~sdmosi;
      if ($urandom_range(0, 15) == 0) vsd_miso = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) SD_MISO = ~SD_MISO;
      #1;
      e_cs = m_vsd | sdss;
      for (int i = 0; i < SLOTS; i++) e_ss[i] = !(m_vsd && m_slot == i) || sdss;
      e_miso = m_vsd ? vsd_miso[m_slot] : SD_MISO;
      chk("rnd_cs",   32'(SD_CS),   32'(e_cs));
      chk("rnd_sck",  32'(SD_SCK),  32'(sdclk & ~e_cs));
      chk("rnd_mosi", 32'(SD_MOSI), 32'(sdmosi & ~e_cs));
      chk("rnd_vss",  32'(vsd_ss),  32'(e_ss));
      chk("rnd_miso", 32'(sdmiso),  32'(e_miso));
      miso_seen = e_miso;
      @(posedge clk_sys);
      model_edge(strb_now, nz_now, sdss, sdmosi, miso_seen);
      #1;
      img_mounted = '0;
      chk("rnd_vsd_sel", 32'(vsd_sel), 32'(m_vsd));
      if (m_vsd) chk("rnd_sel_slot", 32'(sel_slot), 32'(m_slot));
      chk("rnd_reset_img", 32'(reset_img), 32'(rst_left > 0));
      chk("rnd_sd_act",    32'(sd_act),    32'(age < ACT));
      if (strb_now != 0)
        $display("[TB] rnd %0d strobe=%b nz=%b sdss=%b -> vsd_sel=%b sel_slot=%0d", c, strb_now, nz_now, sdss, vsd_sel, sel_slot);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
